// File: rtl/parser_input_arbiter_pkg.sv
// rtl/parser_input_arbiter_pkg.sv - shared FSM encoding, counter width and EOP predicate
package parser_input_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  localparam int GAP_CNT_W      = 4;
  localparam int EOP_CTRL_MAX_W = 64;

  // Any nonzero control/byte-mask value marks the last word of a packet.
  function automatic logic is_eop(input logic [EOP_CTRL_MAX_W-1:0] ctrl);
    return ctrl != '0;
  endfunction

endpackage

// File: rtl/parser_input_arbiter_rr_priority_picker.sv
// rtl/parser_input_arbiter_rr_priority_picker.sv - combinational round-robin pick starting after last_grant
module rr_priority_picker #(
  parameter int NUM_QUEUES = 4,
  parameter int IDX_W      = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1
) (
  input  logic [NUM_QUEUES-1:0] req,
  input  logic [IDX_W-1:0]      last_grant,
  output logic [IDX_W-1:0]      grant,
  output logic                  valid
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Scan from furthest to nearest so the port right after last_grant wins.
  always_comb begin
    grant    = '0;
    valid    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = NUM_QUEUES; i >= 1; i--) begin
      cand     = (int'(last_grant) + i) % NUM_QUEUES;
      cand_idx = IDX_W'(cand);
      if (req[cand_idx]) begin
        grant = cand_idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/parser_input_arbiter.sv
// rtl/parser_input_arbiter.sv - packet-atomic round-robin arbiter feeding one ethernet parser
module parser_input_arbiter
  import parser_input_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_QUEUES = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctrl,
  input  logic [NUM_QUEUES-1:0]            in_wr,
  output logic [NUM_QUEUES-1:0]            in_rdy,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [CTRL_WIDTH-1:0]            out_ctrl,
  output logic                             out_wr,
  output logic [NUM_QUEUES-1:0]            out_src_port,
  output logic                             proto_err
);

  localparam int                IDX_W    = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_QUEUES - 1);

  arb_state_t            state, state_n;
  logic [IDX_W-1:0]      grant, last_grant, pick_idx;
  logic                  pick_valid;
  logic [GAP_CNT_W-1:0]  gap_cnt;
  logic [NUM_QUEUES-1:0] grant_onehot;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [CTRL_WIDTH-1:0] sel_ctrl;
  logic                  sel_wr, sel_eop, accept;

  rr_priority_picker #(
    .NUM_QUEUES (NUM_QUEUES),
    .IDX_W      (IDX_W)
  ) u_picker (
    .req        (in_wr),
    .last_grant (last_grant),
    .grant      (pick_idx),
    .valid      (pick_valid)
  );

  assign grant_onehot = NUM_QUEUES'(1) << grant;
  assign sel_data     = in_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_ctrl     = in_ctrl[int'(grant)*CTRL_WIDTH +: CTRL_WIDTH];
  assign sel_wr       = in_wr[grant];
  assign sel_eop      = is_eop(EOP_CTRL_MAX_W'(sel_ctrl));
  assign accept       = (state == XFER) && sel_wr;

  // Ready depends only on registered state, never on in_wr.
  assign in_rdy = (state == XFER) ? grant_onehot : '0;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (pick_valid) state_n = XFER;
      XFER:    if (accept && sel_eop) state_n = GAP;
      GAP:     if (gap_cnt <= GAP_CNT_W'(1)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      grant        <= '0;
      last_grant   <= LAST_IDX;
      gap_cnt      <= '0;
      out_data     <= '0;
      out_ctrl     <= '0;
      out_wr       <= 1'b0;
      out_src_port <= '0;
      proto_err    <= 1'b0;
    end else begin
      state     <= state_n;
      out_wr    <= accept;
      // The parser cannot stall, so a bubble inside a granted packet is flagged.
      proto_err <= (state == XFER) && !sel_wr;
      if (accept) begin
        out_data     <= sel_data;
        out_ctrl     <= sel_ctrl;
        out_src_port <= grant_onehot;
      end
      if (state == IDLE && pick_valid) grant <= pick_idx;
      if (accept && sel_eop) begin
        last_grant <= grant;
        gap_cnt    <= GAP_CNT_W'(GAP_CYCLES);
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt - GAP_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_parser_input_arbiter.sv
// tb/tb_parser_input_arbiter.sv - self-checking bench with packet-level round-robin reference model
module tb_parser_input_arbiter;

  localparam int DW = 64, CW = 8, NQ = 4, G = 3, MAXW = 256;

  logic             clk = 1'b0;
  logic             reset;
  logic [NQ*DW-1:0] in_data;
  logic [NQ*CW-1:0] in_ctrl;
  logic [NQ-1:0]    in_wr, in_rdy;
  logic [DW-1:0]    out_data;
  logic [CW-1:0]    out_ctrl;
  logic             out_wr;
  logic [NQ-1:0]    out_src_port;
  logic             proto_err;

  parser_input_arbiter #(
    .DATA_WIDTH (DW),
    .CTRL_WIDTH (CW),
    .NUM_QUEUES (NQ),
    .GAP_CYCLES (G)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_ctrl      (in_ctrl),
    .in_wr        (in_wr),
    .in_rdy       (in_rdy),
    .out_data     (out_data),
    .out_ctrl     (out_ctrl),
    .out_wr       (out_wr),
    .out_src_port (out_src_port),
    .proto_err    (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [NQ-1:0] src;
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } exp_t;

  exp_t            exp_q[$];
  logic [CW+DW-1:0] mem[NQ][MAXW];
  int head[NQ], tail[NQ], mptr[NQ];
  int plen[NQ][32];
  int pcnt[NQ], pnext[NQ];
  int m_last;
  logic [NQ-1:0] bubble_arm;
  logic [NQ-1:0] first_src;
  int total, bad, cyc, low_run, mid_low, perr_cnt, perr0, first_wr_cyc, t0;
  bit gap_chk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic add_pkt(input int p, input int len, input logic [CW-1:0] last_ctrl);
    logic [CW-1:0] c;
    for (int w = 0; w < len; w++) begin
      c = '0;
      if (w == len - 1) c = (last_ctrl != '0) ? last_ctrl : CW'($urandom_range(1, 255));
      mem[p][tail[p]] = {c, $urandom(), $urandom()};
      tail[p]++;
    end
    plen[p][pcnt[p]] = len;
    pcnt[p]++;
  endtask

  // Reference: packets leave in round-robin order over ports that still hold packets.
  task automatic build_order();
    bit   found;
    int   p, len;
    exp_t e;
    found = 1'b1;
    while (found) begin
      found = 1'b0;
      p = 0;
      for (int i = 1; i <= NQ; i++) begin
        if (!found && pnext[(m_last + i) % NQ] < pcnt[(m_last + i) % NQ]) begin
          found = 1'b1;
          p = (m_last + i) % NQ;
        end
      end
      if (found) begin
        len = plen[p][pnext[p]];
        for (int w = 0; w < len; w++) begin
          e.sop = (w == 0);
          e.eop = (w == len - 1);
          e.src = NQ'(1) << p;
          {e.ctrl, e.data} = mem[p][mptr[p]];
          mptr[p]++;
          exp_q.push_back(e);
        end
        pnext[p]++;
        m_last = p;
      end
    end
  endtask

  task automatic drive(input logic [NQ-1:0] acc);
    bit has;
    for (int p = 0; p < NQ; p++) begin
      has = (head[p] < tail[p]) && !reset;
      if (has && bubble_arm[p] && acc[p]) begin
        has = 1'b0;
        bubble_arm[p] = 1'b0;
      end
      in_wr[p] = has;
      in_data[p*DW +: DW] = has ? mem[p][head[p]][DW-1:0] : '0;
      in_ctrl[p*CW +: CW] = has ? mem[p][head[p]][CW+DW-1:DW] : '0;
    end
  endtask

  task automatic cycle();
    logic [NQ-1:0] acc;
    exp_t e;
    acc = in_wr & in_rdy;
    @(posedge clk);
    #1;
    cyc++;
    for (int p = 0; p < NQ; p++) if (acc[p] && head[p] < tail[p]) head[p]++;
    if (proto_err === 1'b1) perr_cnt++;
    if (out_wr === 1'b1) begin
      if (first_wr_cyc < 0) begin
        first_wr_cyc = cyc;
        first_src = out_src_port;
      end
      if (exp_q.size() == 0) begin
        chk("unexpected_out_wr", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_ctrl", 64'(out_ctrl), 64'(e.ctrl));
        chk("out_src_port", 64'(out_src_port), 64'(e.src));
        if (e.sop && gap_chk) chk("gap_low_cycles", 64'(low_run), 64'(G + 1));
        if (!e.sop) mid_low += low_run;
        gap_chk = e.eop && (exp_q.size() != 0);
      end
      low_run = 0;
    end else begin
      low_run++;
    end
    drive(acc);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      cycle();
      n++;
    end
    chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    repeat (G + 4) cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_wr"}, 64'(out_wr), 64'd0);
    chk({tag, "_out_data"}, out_data, 64'd0);
    chk({tag, "_out_ctrl"}, 64'(out_ctrl), 64'd0);
    chk({tag, "_out_src_port"}, 64'(out_src_port), 64'd0);
    chk({tag, "_in_rdy"}, 64'(in_rdy), 64'd0);
    chk({tag, "_proto_err"}, 64'(proto_err), 64'd0);
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; low_run = 0; mid_low = 0; perr_cnt = 0;
    first_wr_cyc = -1; first_src = '0; gap_chk = 1'b0;
    m_last = NQ - 1; bubble_arm = '0;
    for (int p = 0; p < NQ; p++) begin
      head[p] = 0; tail[p] = 0; mptr[p] = 0; pcnt[p] = 0; pnext[p] = 0;
    end
    in_wr = '0; in_data = '0; in_ctrl = '0;
    reset = 1'b1;
    repeat (3) cycle();
    check_reset_outputs("reset");
    reset = 1'b0;

    // Port 2, three words, latency and held source tag.
    add_pkt(2, 3, 8'hFF);
    build_order();
    t0 = cyc;
    first_wr_cyc = -1;
    perr0 = perr_cnt;
    drive('0);
    drain("port2");
    chk("first_wr_latency", 64'(first_wr_cyc), 64'(t0 + 2));
    chk("src_held_idle", 64'(out_src_port), 64'b0100);
    chk("port2_no_perr", 64'(perr_cnt - perr0), 64'd0);

    // Single-word packet followed immediately by another from the same port.
    add_pkt(1, 1, 8'h01);
    add_pkt(1, 2, 8'h00);
    build_order();
    drive('0);
    drain("single_word");

    // Bubble mid-packet on port 0.
    add_pkt(0, 3, 8'h00);
    build_order();
    bubble_arm = 4'b0001;
    mid_low = 0;
    perr0 = perr_cnt;
    drive('0);
    drain("bubble");
    chk("bubble_perr_pulses", 64'(perr_cnt - perr0), 64'd1);
    chk("bubble_out_wr_low", 64'(mid_low), 64'd1);

    // Randomised multi-port contention.
    for (int r = 0; r < 4; r++) begin
      int n;
      n = 0;
      for (int p = 0; p < NQ; p++) begin
        int k;
        k = $urandom_range(0, 3);
        for (int j = 0; j < k; j++) add_pkt(p, $urandom_range(1, 4), 8'h00);
        n += k;
      end
      if (n == 0) add_pkt($urandom_range(0, NQ - 1), 2, 8'h00);
      build_order();
      mid_low = 0;
      perr0 = perr_cnt;
      drive('0);
      drain("random");
      chk("random_no_perr", 64'(perr_cnt - perr0), 64'd0);
      chk("random_no_mid_gap", 64'(mid_low), 64'd0);
    end

    // Reset in the middle of a transfer, then full contention.
    add_pkt(3, 6, 8'h00);
    add_pkt(1, 2, 8'h00);
    build_order();
    drive('0);
    t0 = 0;
    while (exp_q.size() > 6 && t0 < 50) begin
      cycle();
      t0++;
    end
    chk("pre_reset_words_seen", 64'(exp_q.size() <= 6), 64'd1);
    reset = 1'b1;
    for (int p = 0; p < NQ; p++) begin
      head[p] = tail[p]; mptr[p] = tail[p]; pnext[p] = pcnt[p];
    end
    exp_q.delete();
    gap_chk = 1'b0;
    m_last = NQ - 1;
    drive('0);
    cycle();
    check_reset_outputs("midxfer_reset");
    reset = 1'b0;
    for (int p = 0; p < NQ; p++) begin
      add_pkt(p, 2, 8'h00);
      add_pkt(p, 2, 8'h00);
    end
    build_order();
    first_wr_cyc = -1;
    perr0 = perr_cnt;
    mid_low = 0;
    drive('0);
    drain("post_reset");
    chk("post_reset_first_src", 64'(first_src), 64'b0001);
    chk("post_reset_no_perr", 64'(perr_cnt - perr0), 64'd0);
    chk("post_reset_no_mid_gap", 64'(mid_low), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parser_input_arbiter.md
# parser_input_arbiter

Packet-atomic round-robin arbiter that shares one ethernet_parser_64bit instance (and the downstream datapath behind it) among NUM_QUEUES input ports. It grants one port per packet, forwards that port's words through a single registered stage, drives the one-hot source-port tag the parser latches, and inserts mandatory idle cycles between packets so the parser's WAIT_EOP state always returns to READ_WORD_1.

## Interface
- DATA_WIDTH, 64, datapath word width
- CTRL_WIDTH, DATA_WIDTH/8, per-word control/byte mask width
- NUM_QUEUES, 4, number of requesting input ports
- GAP_CYCLES, 1, idle cycles forced on out_wr between packets (legal range 1..15)

Ports:
- clk  in  1  single clock domain
- reset  in  1  synchronous, active-high
- in_data  in  NUM_QUEUES*DATA_WIDTH  port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_ctrl  in  NUM_QUEUES*CTRL_WIDTH  nonzero marks the last word (EOP) of a packet
- in_wr  in  NUM_QUEUES  port i has a valid word; held with data stable until accepted
- in_rdy  out  NUM_QUEUES  port i word accepted this cycle when in_wr[i] && in_rdy[i]
- out_data  out  DATA_WIDTH  to parser in_data
- out_ctrl  out  CTRL_WIDTH  to parser in_ctrl
- out_wr  out  1  to parser in_wr
- out_src_port  out  NUM_QUEUES  one-hot granted port, to parser in_scr_port
- proto_err  out  1  one-cycle pulse: granted source bubbled mid-packet

## Operation
- FSM states: IDLE, XFER, GAP. Reset state IDLE.
- IDLE: if any in_wr bit set, pick a port by round-robin starting at last_grant+1 (mod NUM_QUEUES); register grant; go to XFER. No requests: stay.
- XFER: in_rdy = one-hot(grant); all other bits 0. Accepted word is registered to out_data/out_ctrl with out_wr=1 next cycle. Accepted word with in_ctrl!=0 → last_grant<=grant, load gap counter with GAP_CYCLES, go to GAP.
- XFER with in_wr[grant]=0: stay in XFER, out_wr=0 next cycle, pulse proto_err next cycle (parser has no backpressure; a bubble ends its packet). Requests from other ports are ignored.
- GAP: in_rdy=0; decrement counter; at zero go to IDLE. Counter width 4 bits.
- Single-word packet (EOP on first word): XFER lasts one cycle, then GAP.
- out_src_port = one-hot(grant) registered alongside out_data; holds its value between packets.
- Round-robin: last_grant resets to NUM_QUEUES-1, so port 0 wins the first contention. Fairness is per packet, not per word.
- Reset at any point (incl. mid-packet): all state cleared next edge; sources must discard partial packets.

## Timing
- Reset values: out_data=0, out_ctrl=0, out_wr=0, out_src_port=0, in_rdy=0, proto_err=0, grant=0, last_grant=NUM_QUEUES-1.
- Request visible in IDLE at cycle T → XFER at T+1, in_rdy high at T+1, first word accepted T+1, out_wr high T+2.
- Forward latency: one cycle from acceptance to out_wr.
- EOP accepted at cycle E → out_wr last high E+1; out_wr low for exactly GAP_CYCLES+1 cycles minimum (GAP cycles plus IDLE arbitration cycle) before next packet's first word.
- in_rdy is registered-state-derived only (no combinational path from in_wr to in_rdy).

## Structure
- Shared package/header: FSM state encoding (IDLE=0, XFER=1, GAP=2, 2 bits), EOP predicate (ctrl != 0), GAP counter width.
- One sub-module: rr_priority_picker (combinational; inputs req[NUM_QUEUES], last_grant index; outputs grant index and valid). Top holds FSM, counters, output register.

## Test plan
- Reset then port 2 sends 3 words (ctrl 0,0,0xFF) → out_wr high 3 cycles starting T+2, out_src_port=4'b0100, data matches in order, then ≥2 idle cycles; parser reports eth_done with src_port=4.
- Ports 0–3 all request continuously, 2-word packets → grants 0,1,2,3,0 in order; no interleaving of words within a packet.
- Single-word packet (ctrl=0x01) on port 1 → out_wr one cycle, GAP entered immediately, next grant after GAP_CYCLES+1 idle.
- Port 0 drops in_wr for one cycle mid-packet → proto_err one pulse, out_wr low one cycle, grant stays port 0, remaining words forwarded.
- GAP_CYCLES=3, back-to-back requests → exactly 4 out_wr-low cycles between packets.
- Reset asserted mid-XFER → next cycle all outputs at reset values, in_rdy=0, port 0 wins next contention.
